// File: rtl/screen_effects_stage.sv
// Full-screen effect stage after the object priority mux: red hit flash and
// stepped fade-to-black on death, timed in frames, one clock of pixel latency.
module screen_effects_stage #(
  parameter int         FLASH_FRAMES = 24,
  parameter int         FLASH_TOGGLE = 4,
  parameter logic [7:0] FLASH_TINT   = 8'd96,
  parameter int         FADE_STEP    = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] redIn,
  input  logic [7:0] greenIn,
  input  logic [7:0] blueIn,
  input  logic       startOfFrame,
  input  logic       hitPulse,
  input  logic       deathPulse,
  input  logic       restartPulse,
  output logic [7:0] redOut,
  output logic [7:0] greenOut,
  output logic [7:0] blueOut,
  output logic       fadeDone
);

  localparam int FW = $clog2(FLASH_FRAMES + 1);
  localparam int TW = $clog2(FLASH_TOGGLE + 1);
  localparam int SW = $clog2(FADE_STEP + 1);

  typedef enum logic [1:0] {IDLE, FLASH, FADE, BLACK} state_t;

  state_t          state_reg, state_next;
  logic [FW-1:0]   frame_cnt_reg, frame_cnt_next;
  logic [TW-1:0]   tog_cnt_reg, tog_cnt_next;
  logic            tint_reg, tint_next;
  logic [SW-1:0]   step_cnt_reg, step_cnt_next;
  logic [3:0]      level_reg, level_next;
  logic [2:0][7:0] pix_in, pix_next, pix_reg;
  logic [7:0]      scaled [3];
  logic [8:0]      tint_sum;
  logic [7:0]      tinted_red;

  // Channel 2 is red, 1 green, 0 blue.
  assign pix_in = {redIn, greenIn, blueIn};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_scale
      logic [11:0] prod;
      assign prod       = {4'd0, pix_in[gi]} * {8'd0, level_reg};
      assign scaled[gi] = prod[10:3];
    end
  endgenerate

  assign tint_sum   = {1'b0, redIn} + {1'b0, FLASH_TINT};
  assign tinted_red = tint_sum[8] ? 8'hFF : tint_sum[7:0];

  always_comb begin
    state_next     = state_reg;
    frame_cnt_next = frame_cnt_reg;
    tog_cnt_next   = tog_cnt_reg;
    tint_next      = tint_reg;
    step_cnt_next  = step_cnt_reg;
    level_next     = level_reg;
    if (restartPulse) begin
      state_next     = IDLE;
      frame_cnt_next = '0;
      tog_cnt_next   = '0;
      tint_next      = 1'b0;
      step_cnt_next  = '0;
      level_next     = 4'd8;
    end else if (deathPulse && (state_reg == IDLE || state_reg == FLASH)) begin
      state_next     = FADE;
      frame_cnt_next = '0;
      tog_cnt_next   = '0;
      tint_next      = 1'b0;
      step_cnt_next  = '0;
      level_next     = 4'd8;
    end else if (hitPulse && (state_reg == IDLE || state_reg == FLASH)) begin
      state_next     = FLASH;
      frame_cnt_next = '0;
      tog_cnt_next   = '0;
      tint_next      = 1'b1;
    end else if (startOfFrame) begin
      case (state_reg)
        FLASH: begin
          if (frame_cnt_reg == FW'(FLASH_FRAMES - 1)) begin
            state_next     = IDLE;
            frame_cnt_next = '0;
            tog_cnt_next   = '0;
            tint_next      = 1'b0;
          end else begin
            frame_cnt_next = frame_cnt_reg + 1'b1;
            // Separate half-period counter avoids a modulo on frame count.
            if (tog_cnt_reg == TW'(FLASH_TOGGLE - 1)) begin
              tog_cnt_next = '0;
              tint_next    = ~tint_reg;
            end else begin
              tog_cnt_next = tog_cnt_reg + 1'b1;
            end
          end
        end
        FADE: begin
          if (step_cnt_reg == SW'(FADE_STEP - 1)) begin
            step_cnt_next = '0;
            level_next    = level_reg - 1'b1;
            if (level_reg == 4'd1) state_next = BLACK;
          end else begin
            step_cnt_next = step_cnt_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    pix_next = pix_in;
    case (state_reg)
      FLASH:   if (tint_reg) pix_next[2] = tinted_red;
      FADE:    pix_next = {scaled[2], scaled[1], scaled[0]};
      BLACK:   pix_next = '0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      frame_cnt_reg <= '0;
      tog_cnt_reg   <= '0;
      tint_reg      <= 1'b0;
      step_cnt_reg  <= '0;
      level_reg     <= 4'd8;
      pix_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      frame_cnt_reg <= frame_cnt_next;
      tog_cnt_reg   <= tog_cnt_next;
      tint_reg      <= tint_next;
      step_cnt_reg  <= step_cnt_next;
      level_reg     <= level_next;
      pix_reg       <= pix_next;
    end
  end

  assign redOut   = pix_reg[2];
  assign greenOut = pix_reg[1];
  assign blueOut  = pix_reg[0];
  assign fadeDone = (state_reg == BLACK);

endmodule

// File: tb/tb_screen_effects_stage.sv
// Directed bench for screen_effects_stage: vector table plus hand-written
// flash, retrigger, fade, black-hold, restart and async-reset sequences.
module tb_screen_effects_stage;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] redIn = '0, greenIn = '0, blueIn = '0;
  logic       startOfFrame = 1'b0, hitPulse = 1'b0, deathPulse = 1'b0, restartPulse = 1'b0;
  logic [7:0] redOut, greenOut, blueOut;
  logic       fadeDone;

  int checks = 0;
  int errors = 0;

  screen_effects_stage dut (
    .clk(clk), .reset(reset),
    .redIn(redIn), .greenIn(greenIn), .blueIn(blueIn),
    .startOfFrame(startOfFrame), .hitPulse(hitPulse),
    .deathPulse(deathPulse), .restartPulse(restartPulse),
    .redOut(redOut), .greenOut(greenOut), .blueOut(blueOut),
    .fadeDone(fadeDone)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] r, g, b;
    logic       sof, hit, death, restart;
    logic [7:0] er, eg, eb;
    logic       efd;
  } vec_t;

  vec_t tbl [11];

  task automatic cyc(input logic [7:0] r, g, b, input logic sof, hit, death, rst);
    @(negedge clk);
    redIn = r; greenIn = g; blueIn = b;
    startOfFrame = sof; hitPulse = hit; deathPulse = death; restartPulse = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] er, eg, eb, input logic efd);
    checks++;
    if (redOut !== er || greenOut !== eg || blueOut !== eb || fadeDone !== efd) begin
      errors++;
      $display("FAIL %s: got rgb=%02h,%02h,%02h done=%0b, expected rgb=%02h,%02h,%02h done=%0b",
               name, redOut, greenOut, blueOut, fadeDone, er, eg, eb, efd);
    end else begin
      $display("ok   %s: rgb=%02h,%02h,%02h done=%0b", name, redOut, greenOut, blueOut, fadeDone);
    end
  endtask

  // Expected red for a pixel registered while flashing at the given frame.
  function automatic logic [7:0] flash_red(input int frame, input logic [7:0] r);
    int s;
    if (((frame / 4) % 2) != 0) return r;
    s = r + 96;
    return (s > 255) ? 8'hFF : 8'(s);
  endfunction

  function automatic logic [7:0] fade_val(input logic [7:0] v, input int lvl);
    return 8'((int'(v) * lvl) >> 3);
  endfunction

  initial begin
    tbl[0]  = '{8'h12, 8'h34, 8'h56, 1'b0, 1'b0, 1'b0, 1'b0, 8'h12, 8'h34, 8'h56, 1'b0};
    tbl[1]  = '{8'hC0, 8'h11, 8'h22, 1'b0, 1'b1, 1'b0, 1'b0, 8'hC0, 8'h11, 8'h22, 1'b0};
    tbl[2]  = '{8'hC0, 8'h11, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 8'h11, 8'h22, 1'b0};
    tbl[3]  = '{8'h20, 8'h33, 8'h44, 1'b0, 1'b0, 1'b0, 1'b0, 8'h80, 8'h33, 8'h44, 1'b0};
    tbl[4]  = '{8'h9F, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 8'h00, 8'hFF, 1'b0};
    tbl[5]  = '{8'h20, 8'h01, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 8'h80, 8'h01, 8'h02, 1'b0};
    tbl[6]  = '{8'h20, 8'h01, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 8'h80, 8'h01, 8'h02, 1'b0};
    tbl[7]  = '{8'h20, 8'h01, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 8'h80, 8'h01, 8'h02, 1'b0};
    tbl[8]  = '{8'h20, 8'h01, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 8'h80, 8'h01, 8'h02, 1'b0};
    tbl[9]  = '{8'h20, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 8'h20, 8'h01, 8'h02, 1'b0};
    tbl[10] = '{8'hC0, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 8'hC0, 8'h01, 8'h02, 1'b0};

    // Reset held three cycles with live inputs.
    redIn = 8'hAA; greenIn = 8'hBB; blueIn = 8'hCC;
    repeat (3) @(posedge clk);
    #1 chk("reset_state", 8'h00, 8'h00, 8'h00, 1'b0);
    @(negedge clk) reset = 1'b0;

    // Pass-through, hit saturation, first four strobes tinted then normal.
    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].r, tbl[i].g, tbl[i].b, tbl[i].sof, tbl[i].hit, tbl[i].death, tbl[i].restart);
      chk($sformatf("vec%0d", i), tbl[i].er, tbl[i].eg, tbl[i].eb, tbl[i].efd);
    end

    // Remaining strobes of the flash: frames 4..23, then IDLE.
    for (int s = 5; s <= 24; s++) begin
      cyc(8'h20, 8'h05, 8'h06, 1'b1, 1'b0, 1'b0, 1'b0);
      chk($sformatf("flash_strobe%0d", s), flash_red(s - 1, 8'h20), 8'h05, 8'h06, 1'b0);
    end
    cyc(tbl[10].r, tbl[10].g, tbl[10].b, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("flash_end_idle", tbl[10].er, tbl[10].eg, tbl[10].eb, tbl[10].efd);

    // Retrigger from the normal phase at frame 6.
    cyc(8'h20, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int s = 1; s <= 6; s++) cyc(8'h20, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(8'h20, 8'h07, 8'h08, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("retrig_pre_normal", 8'h20, 8'h07, 8'h08, 1'b0);
    for (int s = 1; s <= 24; s++) begin
      cyc(8'h20, 8'h07, 8'h08, 1'b1, 1'b0, 1'b0, 1'b0);
      chk($sformatf("retrig_strobe%0d", s), flash_red(s - 1, 8'h20), 8'h07, 8'h08, 1'b0);
    end
    cyc(8'hC0, 8'h07, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("retrig_end_idle", 8'hC0, 8'h07, 8'h08, 1'b0);

    // Restart outranks death: stays IDLE, no fading after six strobes.
    cyc(8'h40, 8'h40, 8'h40, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int s = 1; s <= 6; s++) cyc(8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("restart_over_death", 8'hFF, 8'hFF, 8'hFF, 1'b0);

    // Death and hit together: fade wins (a flash would tint red to A0).
    cyc(8'h40, 8'h40, 8'h40, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(8'h40, 8'h40, 8'h40, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("death_over_hit", 8'h40, 8'h40, 8'h40, 1'b0);
    for (int s = 1; s <= 48; s++) begin
      cyc(8'hFF, 8'hFF, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0);
      chk($sformatf("fade_strobe%0d", s), fade_val(8'hFF, 8 - (s - 1) / 6),
          fade_val(8'hFF, 8 - (s - 1) / 6), fade_val(8'h80, 8 - (s - 1) / 6), (s == 48));
    end

    // BLACK holds through strobes, hits and deaths.
    cyc(8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("black_hit", 8'h00, 8'h00, 8'h00, 1'b1);
    cyc(8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("black_death", 8'h00, 8'h00, 8'h00, 1'b1);
    cyc(8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("black_hold", 8'h00, 8'h00, 8'h00, 1'b1);
    cyc(8'h12, 8'h34, 8'h56, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("restart_edge", 8'h00, 8'h00, 8'h00, 1'b0);
    cyc(8'h12, 8'h34, 8'h56, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("restart_pass", 8'h12, 8'h34, 8'h56, 1'b0);

    // Fade down to level 3, then reset between edges.
    cyc(8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int s = 1; s <= 30; s++) cyc(8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("fade_level3", 8'h5F, 8'h5F, 8'h5F, 1'b0);
    #2 reset = 1'b1;
    #1 chk("async_reset", 8'h00, 8'h00, 8'h00, 1'b0);
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    cyc(8'h12, 8'h34, 8'h56, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_reset_pass", 8'h12, 8'h34, 8'h56, 1'b0);
    cyc(8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_reset_level8", 8'hFF, 8'hFF, 8'hFF, 1'b0);
    for (int s = 1; s <= 6; s++) cyc(8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_reset_level7", 8'hDF, 8'hDF, 8'hDF, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
